// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if: sample stream, FFT core control and lane data bundle for fft_frame_loader
interface fft_frame_loader_if #(
  parameter int DW = 64
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          fft_start;
  logic          fft_done;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [DW-1:0] d2;
  logic [DW-1:0] d3;
  logic          busy;
  logic          frame_done;
  logic          err;
  modport master (
    output s_valid, s_data, s_last, fft_done,
    input  s_ready, fft_start, d0, d1, d2, d3, busy, frame_done, err
  );
  modport slave (
    input  s_valid, s_data, s_last, fft_done,
    output s_ready, fft_start, d0, d1, d2, d3, busy, frame_done, err
  );
endinterface

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: buffers one N_POINTS frame and streams it as quads into a 4-lane FFT core
// Optional S_LAST framing check with sticky err: define LDR_LAST_CHECK_EN
module fft_frame_loader #(
  parameter int N_POINTS = 256,
  parameter int DW       = 64,
  parameter int LOAD_DLY = 1
) (
  input logic               clk,
  input logic               rst,
  fft_frame_loader_if.slave bus
);
  localparam int FW = $clog2(N_POINTS);
  localparam int QW = $clog2(N_POINTS / 4);
  localparam int CW = LOAD_DLY > 1 ? $clog2(LOAD_DLY) : 1;
  typedef enum logic [2:0] {FILL, LAUNCH, DELAY, STREAM, WAIT} state_t;
  state_t state, state_n;
  logic [FW-1:0] fill_cnt, fill_cnt_n;
  logic [QW-1:0] q, q_n;
  logic [CW-1:0] dly_cnt, dly_cnt_n;
  logic [DW-1:0] mem [N_POINTS];
  logic [DW-1:0] dq [4];
  logic accept, last_k, bad_early, bad_late, frame_done_q, err_q;
  assign accept = bus.s_valid & bus.s_ready;
  assign last_k = fill_cnt == FW'(N_POINTS - 1);
`ifdef LDR_LAST_CHECK_EN
  assign bad_early = accept & bus.s_last & ~last_k;
  assign bad_late  = accept & ~bus.s_last & last_k;
`else
  logic unused_last;
  assign unused_last = bus.s_last;
  assign bad_early = 1'b0;
  assign bad_late  = 1'b0;
`endif
  assign bus.s_ready    = state == FILL && !rst;
  assign bus.fft_start  = state == LAUNCH;
  assign bus.busy       = state != FILL;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;
  assign bus.d0 = dq[0];
  assign bus.d1 = dq[1];
  assign bus.d2 = dq[2];
  assign bus.d3 = dq[3];
  always_comb begin
    state_n    = state;
    fill_cnt_n = fill_cnt;
    q_n        = '0;
    dly_cnt_n  = '0;
    case (state)
      FILL: if (accept) begin
        fill_cnt_n = bad_early ? '0 : fill_cnt + 1'b1;
        state_n    = last_k ? LAUNCH : FILL;
      end
      LAUNCH: state_n = LOAD_DLY == 0 ? STREAM : DELAY;
      DELAY: begin
        dly_cnt_n = dly_cnt + 1'b1;
        state_n   = dly_cnt == CW'(LOAD_DLY - 1) ? STREAM : DELAY;
      end
      STREAM: begin
        q_n     = q + 1'b1;
        state_n = q == QW'(N_POINTS / 4 - 1) ? WAIT : STREAM;
      end
      WAIT: state_n = bus.fft_done ? FILL : WAIT;
      default: state_n = FILL;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state        <= FILL;
      fill_cnt     <= '0;
      q            <= '0;
      dly_cnt      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 4; i++) dq[i] <= '0;
    end else begin
      state        <= state_n;
      fill_cnt     <= fill_cnt_n;
      q            <= q_n;
      dly_cnt      <= dly_cnt_n;
      frame_done_q <= state == WAIT && bus.fft_done;
      err_q        <= err_q | bad_early | bad_late;
      // lanes are loaded on the edge entering each stream cycle, so q tracks the quad on display
      for (int i = 0; i < 4; i++) dq[i] <= state_n == STREAM ? mem[{q_n, 2'(i)}] : '0;
    end
  always_ff @(posedge clk)
    if (accept) mem[fill_cnt] <= bus.s_data;
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: scoreboard bench; stimulus queues expected starts and quads, monitors compare
module tb_fft_frame_loader;
  localparam int LDLY = 1;
  typedef struct {int c; logic st; logic [63:0] d;} ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  int acc_cnt = 0;
  int err_due = -1;
  int done_due = -1;
  int stream_at = 0;
  int qi = 0;
  logic streaming = 1'b0;
  logic waiting = 1'b0;
  logic active = 1'b0;
  logic [63:0] fb [256];
  logic [63:0] cur [256];
  logic [63:0] exp_q [$];
  int exp_start [$];
  ev_t q0 [$];

  fft_frame_loader_if #(.DW(64)) bus ();
  fft_frame_loader_if #(.DW(16)) bus0 ();
  fft_frame_loader #(.N_POINTS(256), .DW(64), .LOAD_DLY(LDLY)) dut (.clk(clk), .rst(rst), .bus(bus));
  fft_frame_loader #(.N_POINTS(8), .DW(16), .LOAD_DLY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, want);
    end
  endfunction

  function automatic logic [63:0] pat_val(input int p, input int k);
    return p == 0 ? {32'(k), 32'h0} : {16'(p), 16'(k), 16'hC000 ^ 16'(p), 16'h0F00 ^ 16'(k)};
  endfunction

  task automatic accepted(input logic [63:0] v, input logic last);
`ifdef LDR_LAST_CHECK_EN
    if (last && acc_cnt != 255) begin
      if (err_due < 0) err_due = cyc + 1;
      acc_cnt = 0;
      return;
    end
    if (!last && acc_cnt == 255 && err_due < 0) err_due = cyc + 1;
`endif
    fb[acc_cnt] = v;
    acc_cnt++;
    if (acc_cnt == 256) begin
      for (int i = 0; i < 256; i++) exp_q.push_back(fb[i]);
      exp_start.push_back(cyc + 1);
      acc_cnt = 0;
    end
  endtask

  task automatic send_sample(input logic [63:0] v, input logic last);
    logic rdy;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    bus.s_last  = last;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      if (rdy) accepted(v, last);
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    vecs++;
    errs++;
    $display("FAIL s_ready timeout at cycle %0d: got 0 expected 1", cyc);
  endtask

  task automatic feed_frame(input int p, input int n, input int last_at, input bit gap);
    for (int k = 0; k < n; k++) begin
      send_sample(pat_val(p, k), k == last_at);
      if (gap) begin
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    acc_cnt = 0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_done();
    bus.fft_done = 1'b1;
    @(posedge clk);
    #1 bus.fft_done = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    chk("frame_done", 256'(bus.frame_done), 256'(cyc == done_due));
    if (cyc == done_due) active = 1'b0;
    if (waiting && bus.fft_done) begin
      done_due = cyc + 1;
      waiting = 1'b0;
    end
    if (bus.fft_start) begin
      if (exp_start.size() == 0 || exp_q.size() < 256) begin
        vecs++;
        errs++;
        $display("FAIL fft_start at cycle %0d: got 1 expected 0", cyc);
      end else begin
        chk("start_cycle", 256'(cyc), 256'(exp_start.pop_front()));
        for (int i = 0; i < 256; i++) cur[i] = exp_q.pop_front();
        streaming = 1'b1;
        stream_at = cyc + 1 + LDLY;
        qi = 0;
        active = 1'b1;
      end
    end
    if (streaming && cyc >= stream_at) begin
      chk("quad", 256'({bus.d3, bus.d2, bus.d1, bus.d0}),
          256'({cur[4*qi+3], cur[4*qi+2], cur[4*qi+1], cur[4*qi]}));
      qi++;
      if (qi == 64) begin
        streaming = 1'b0;
        waiting = 1'b1;
      end
    end else chk("d_idle", 256'({bus.d3, bus.d2, bus.d1, bus.d0}), 256'(0));
    chk("busy", 256'(bus.busy), 256'(active));
    chk("s_ready", 256'(bus.s_ready), 256'(!active && !rst));
    chk("err", 256'(bus.err), 256'(err_due >= 0 && cyc >= err_due));
    if (rst) begin
      streaming = 1'b0;
      waiting = 1'b0;
      active = 1'b0;
      done_due = -1;
      err_due = -1;
    end
  end

  initial forever begin
    @(negedge clk);
    while (q0.size() > 0 && q0[0].c == cyc) begin
      ev_t e;
      e = q0.pop_front();
      chk("dly0_start", 256'(bus0.fft_start), 256'(e.st));
      chk("dly0_quad", 256'({bus0.d3, bus0.d2, bus0.d1, bus0.d0}), 256'(e.d));
    end
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.fft_done = 1'b0;
    bus0.s_valid = 1'b0;
    bus0.s_data = '0;
    bus0.s_last = 1'b0;
    bus0.fft_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    feed_frame(0, 256, 255, 1'b0);
    repeat (75) @(posedge clk);
    #1 pulse_done();
    repeat (3) @(posedge clk);
    #1 feed_frame(1, 256, 255, 1'b1);
    fork
      begin
        repeat (8) @(posedge clk);
        #1 pulse_done();
        repeat (67) @(posedge clk);
        #1 pulse_done();
      end
      feed_frame(2, 256, 255, 1'b0);
    join
    repeat (32) @(posedge clk);
    #1 do_reset(2);
    feed_frame(3, 100, -1, 1'b0);
    do_reset(2);
    feed_frame(4, 256, 255, 1'b0);
    repeat (75) @(posedge clk);
    #1 pulse_done();
    repeat (3) @(posedge clk);
`ifdef LDR_LAST_CHECK_EN
    #1 feed_frame(5, 100, 99, 1'b0);
    feed_frame(6, 256, 255, 1'b0);
    repeat (75) @(posedge clk);
    #1 pulse_done();
    repeat (3) @(posedge clk);
`endif
    #1;
    for (int k = 0; k < 8; k++) begin
      bus0.s_valid = 1'b1;
      bus0.s_data = 16'h1100 + 16'(k);
      @(negedge clk);
      chk("dly0_ready", 256'(bus0.s_ready), 256'(1));
      if (k == 7) begin
        q0.push_back('{cyc + 1, 1'b1, 64'h0});
        q0.push_back('{cyc + 2, 1'b0, 64'h1103_1102_1101_1100});
        q0.push_back('{cyc + 3, 1'b0, 64'h1107_1106_1105_1104});
        q0.push_back('{cyc + 4, 1'b0, 64'h0});
      end
      @(posedge clk);
      #1;
    end
    bus0.s_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pending_starts", 256'(exp_start.size()), 256'(0));
    chk("pending_dly0", 256'(q0.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
